decodificador_multiplexado: RTL and testbench
=============================================

# decodificador_multiplexado

Parametrised, time-multiplexed BCD-to-7-segment display driver for N digits. It supersedes the single-digit combinational BCD decoder for the comparator's multi-digit readout. A packed BCD word is captured on a load strobe and buffered until the next frame boundary, so updates never tear mid-scan. One shared segment bus is driven while a one-hot digit select scans the digits, with optional leading-zero blanking and detection of invalid BCD.

## Interface
- N_DIGITS, 4, number of digits scanned; must be ≥1.
- PRESCALER, 1000, clock cycles each digit is held; must be ≥1 (1 = advance every cycle).

- PORT_CLK  in  1  single clock; all state updates on its rising edge.
- PORT_RST_N  in  1  reset, asynchronous, active-low.
- PORT_LOAD  in  1  one-cycle strobe; captures PORT_BCD.
- PORT_BCD  in  4*N_DIGITS  packed BCD; nibble i (bits 4i+3:4i) is digit i, digit 0 least significant.
- PORT_BLANK_EN  in  1  1 = suppress leading zeros; sampled live every cycle.
- PORT_DISPLAY  out  7  segments {g,f,e,d,c,b,a}, active-high, registered.
- PORT_DIGIT_SEL  out  N_DIGITS  one-hot active-high digit enable, registered.
- PORT_FRAME  out  1  one-cycle pulse on each scan wrap (digit N-1 → 0).
- PORT_ERR  out  1  1 while the displayed word contains a nibble >9.

## Operation
- State: prescaler count (0..PRESCALER-1), digit index (0..N_DIGITS-1), display register, pending register with valid flag.
- Tick: the cycle in which prescaler = PRESCALER-1. On a tick, the prescaler returns to 0 and the index advances. Otherwise the prescaler increments.
- Index sequence: 0,1,…,N_DIGITS-1, then 0 again. Wrap tick = tick with index = N_DIGITS-1. With N_DIGITS=1, every tick is a wrap tick.
- Load not on a wrap tick: PORT_BCD → pending, valid set. A second load in the same frame overwrites the first; only the last one is displayed.
- Load on a wrap tick: PORT_BCD goes straight to the display register (bypass). Pending valid is cleared.
- Wrap tick without load, pending valid: pending → display register, valid cleared.
- Decode per nibble: 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7C, 7→07, 8→7F, 9→67 (hex). Any nibble 10–15 → 40 (dash).
- Blanking: digit i>0 outputs 00 when PORT_BLANK_EN=1 and nibbles i..N_DIGITS-1 of the display register are all 0. Digit 0 is never blanked.
- PORT_ERR is recomputed only when the display register is written: 1 if any nibble >9, else 0.
- Modes are fixed: no decimal point, no hex glyphs.

## Timing
- Reset values (asserted asynchronously, held while PORT_RST_N=0):
  - prescaler=0, index=0, display=0, pending invalid
  - PORT_DIGIT_SEL=one-hot bit 0, PORT_DISPLAY=3F
  - PORT_FRAME=0, PORT_ERR=0
- PORT_DIGIT_SEL and PORT_DISPLAY are updated on the same edge from next-state values, so they always change together. They never show a segment pattern for the wrong digit.
- Each digit is held for exactly PRESCALER cycles; one full frame is N_DIGITS*PRESCALER cycles.
- PORT_FRAME is high during the cycle after a wrap-tick edge, i.e. the first cycle digit 0 is displayed.
- A blanking change takes effect on the edge after PORT_BLANK_EN changes.
- Load-to-visible latency:
  - via pending: the value appears on digit 0 at the next wrap, at most N_DIGITS*PRESCALER cycles later.
  - via bypass: the value appears on digit 0 on the very next edge.
- Reset mid-scan clears all state immediately, including pending data. After deassertion, the first tick occurs PRESCALER cycles later.

## Test plan
- Reset, N_DIGITS=4, PRESCALER=2: during and after reset, before any tick → DIGIT_SEL=0001, DISPLAY=3F, FRAME=0, ERR=0.
- Load 16'h1234, BLANK_EN=0 → after next FRAME, the scan shows:
  - DIGIT_SEL=0001 with 66, 0010 with 4F, 0100 with 5B, 1000 with 06
  - each held 2 cycles, then the sequence repeats
- Load 16'h0070:
  - BLANK_EN=1 → digits 0..3 show 3F, 07, 00, 00
  - toggle BLANK_EN=0 → digits 2 and 3 show 3F on the next edge of their slot
- Load 16'h00A5 → at wrap, ERR=1 and digit1 shows 40. Then load 16'h0009 → ERR=0 after the next wrap.
- Load 16'h0001 then 16'h0002 within one frame → only 06 never appears and digit0 shows 5B. Load 16'h0008 coincident with a wrap tick → digit0 shows 7F on the next edge.
- Assert PORT_RST_N=0 while DIGIT_SEL=0100 with a pending load outstanding → outputs go to reset values without a clock edge. After release, the pending value is never displayed.

Source files
------------

// File: rtl/decodificador_multiplexado.sv
// -----------------------------------------------------------------------------
// decodificador_multiplexado
// Time-multiplexed BCD-to-7-segment driver for N_DIGITS digits. A packed BCD
// word is captured on i_load and held in a pending buffer until the scan wraps
// back to digit 0, so a frame never mixes old and new digits. One shared
// segment bus is driven while a one-hot select walks the digits.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_load       one-cycle strobe, captures i_bcd
//   i_bcd        packed BCD, nibble i = digit i (digit 0 least significant)
//   i_blank_en   1 = suppress leading zeros (sampled every cycle)
//   o_display    segments {g,f,e,d,c,b,a}, active-high
//   o_digit_sel  one-hot digit enable, active-high
//   o_frame      one-cycle pulse in the first cycle of digit 0 after a wrap
//   o_err        1 while the displayed word holds a nibble > 9
// -----------------------------------------------------------------------------
module decodificador_multiplexado #(
    parameter int unsigned N_DIGITS  = 4,
    parameter int unsigned PRESCALER = 1000
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_load,
    input  logic [4*N_DIGITS-1:0]   i_bcd,
    input  logic                    i_blank_en,
    output logic [6:0]              o_display,
    output logic [N_DIGITS-1:0]     o_digit_sel,
    output logic                    o_frame,
    output logic                    o_err
);

    localparam int unsigned PW = (PRESCALER > 1) ? $clog2(PRESCALER) : 1;
    localparam int unsigned IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned BW = 4 * N_DIGITS;

    localparam logic [PW-1:0] P_LAST = PW'(PRESCALER - 1);
    localparam logic [IW-1:0] I_LAST = IW'(N_DIGITS - 1);

    // BCD glyphs; anything above 9 is shown as a dash
    function automatic logic [6:0] f_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7C;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h67;
            default: seg = 7'h40;
        endcase
        return seg;
    endfunction

    logic [PW-1:0]       r_presc;
    logic [IW-1:0]       r_idx;
    logic [BW-1:0]       r_disp;
    logic [BW-1:0]       r_pend;
    logic                r_pend_vld;
    logic [6:0]          r_display;
    logic [N_DIGITS-1:0] r_digit_sel;
    logic                r_frame;
    logic                r_err;

    logic                w_tick;
    logic                w_wrap;
    logic [PW-1:0]       w_presc_nxt;
    logic [IW-1:0]       w_idx_nxt;
    logic                w_disp_we;
    logic [BW-1:0]       w_disp_nxt;
    logic                w_err_nxt;
    logic [N_DIGITS-1:0] w_lz;
    logic                w_zero_run;
    logic [3:0]          w_nib;
    logic                w_blank;
    logic [6:0]          w_seg_nxt;
    logic [N_DIGITS-1:0] w_sel_nxt;

    // Scan timing and display-register update
    always_comb begin
        w_tick      = (r_presc == P_LAST);
        w_wrap      = w_tick && (r_idx == I_LAST);
        w_presc_nxt = w_tick ? '0 : r_presc + PW'(1);
        w_idx_nxt   = r_idx;
        if (w_tick) begin
            w_idx_nxt = w_wrap ? '0 : r_idx + IW'(1);
        end

        // a load landing on the wrap tick bypasses the pending buffer
        w_disp_we  = w_wrap && (i_load || r_pend_vld);
        w_disp_nxt = r_disp;
        if (w_wrap && i_load) begin
            w_disp_nxt = i_bcd;
        end else if (w_wrap && r_pend_vld) begin
            w_disp_nxt = r_pend;
        end

        w_err_nxt = 1'b0;
        for (int i = 0; i < int'(N_DIGITS); i++) begin
            if (w_disp_nxt[4*i +: 4] > 4'd9) begin
                w_err_nxt = 1'b1;
            end
        end
    end

    // Next segment pattern and select, both derived from the next-state index
    always_comb begin
        // w_lz[i]: nibbles i..N_DIGITS-1 of the next display word are all zero
        w_lz       = '0;
        w_zero_run = 1'b1;
        for (int i = int'(N_DIGITS) - 1; i >= 0; i--) begin
            w_zero_run = w_zero_run && (w_disp_nxt[4*i +: 4] == 4'd0);
            w_lz[i]    = w_zero_run;
        end

        w_nib     = 4'd0;
        w_blank   = 1'b0;
        w_sel_nxt = '0;
        for (int i = 0; i < int'(N_DIGITS); i++) begin
            if (w_idx_nxt == IW'(i)) begin
                w_nib        = w_disp_nxt[4*i +: 4];
                w_blank      = (i != 0) && i_blank_en && w_lz[i];
                w_sel_nxt[i] = 1'b1;
            end
        end
        w_seg_nxt = w_blank ? 7'h00 : f_seg(w_nib);
    end

    // State and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_presc     <= '0;
            r_idx       <= '0;
            r_disp      <= '0;
            r_pend      <= '0;
            r_pend_vld  <= 1'b0;
            r_display   <= 7'h3F;
            r_digit_sel <= N_DIGITS'(1);
            r_frame     <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_presc     <= w_presc_nxt;
            r_idx       <= w_idx_nxt;
            r_disp      <= w_disp_nxt;
            r_display   <= w_seg_nxt;
            r_digit_sel <= w_sel_nxt;
            r_frame     <= w_wrap;
            if (w_disp_we) begin
                r_err <= w_err_nxt;
            end
            // last load before the wrap wins; the wrap always drains the buffer
            if (i_load && !w_wrap) begin
                r_pend     <= i_bcd;
                r_pend_vld <= 1'b1;
            end else if (w_wrap) begin
                r_pend_vld <= 1'b0;
            end
        end
    end

    assign o_display   = r_display;
    assign o_digit_sel = r_digit_sel;
    assign o_frame     = r_frame;
    assign o_err       = r_err;

endmodule

// File: tb/tb_decodificador_multiplexado.sv
// -----------------------------------------------------------------------------
// tb_decodificador_multiplexado
// Directed bench for the multiplexed display driver (N_DIGITS=4, PRESCALER=2).
// Stimulus pushes the expected contents of a whole frame into a queue; the
// monitor pops one entry at each o_frame pulse and checks all 8 cycles.
// -----------------------------------------------------------------------------
module tb_decodificador_multiplexado;

    localparam int unsigned N = 4;
    localparam int unsigned P = 2;
    localparam int unsigned FRAME_CYC = N * P;

    logic          clk;
    logic          rst_n;
    logic          load;
    logic [4*N-1:0] bcd;
    logic          blank_en;
    logic [6:0]    display;
    logic [N-1:0]  digit_sel;
    logic          frame;
    logic          err;

    typedef struct packed {
        logic [7:0][6:0] seg;
        logic            err;
    } frame_t;

    frame_t exp_q[$];
    bit     busy;
    int     n_checks;
    int     n_fail;

    decodificador_multiplexado #(
        .N_DIGITS  (N),
        .PRESCALER (P)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_load      (load),
        .i_bcd       (bcd),
        .i_blank_en  (blank_en),
        .o_display   (display),
        .o_digit_sel (digit_sel),
        .o_frame     (frame),
        .o_err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    function automatic frame_t mk(input logic [6:0] d0, input logic [6:0] d1,
                                  input logic [6:0] d2, input logic [6:0] d3,
                                  input logic e);
        frame_t f;
        f.seg[0] = d0; f.seg[1] = d0;
        f.seg[2] = d1; f.seg[3] = d1;
        f.seg[4] = d2; f.seg[5] = d2;
        f.seg[6] = d3; f.seg[7] = d3;
        f.err    = e;
        return f;
    endfunction

    // Monitor: pops an expected frame at each o_frame pulse and checks every cycle
    initial begin
        frame_t cur;
        int     cyc;
        cur  = '0;
        cyc  = 0;
        busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!busy && rst_n && frame && exp_q.size() > 0) begin
                cur  = exp_q.pop_front();
                busy = 1'b1;
                cyc  = 0;
            end
            if (busy) begin
                chk($sformatf("sel_c%0d", cyc), 32'(digit_sel), 32'(4'(4'b0001 << (cyc / int'(P)))));
                chk($sformatf("seg_c%0d", cyc), 32'(display), 32'(cur.seg[cyc]));
                chk($sformatf("frame_c%0d", cyc), 32'(frame), 32'(cyc == 0));
                chk($sformatf("err_c%0d", cyc), 32'(err), 32'(cur.err));
                cyc++;
                if (cyc == int'(FRAME_CYC)) busy = 1'b0;
            end
        end
    end

    task automatic tick_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // step to a negedge where o_frame is low, so a push never races the monitor
    task automatic wait_quiet();
        int n;
        n = 0;
        @(negedge clk);
        while (frame && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (frame) chk("quiet_timeout", 32'(frame), 32'd0);
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        @(negedge clk);
        while (!frame && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!frame) chk("frame_timeout", 32'(frame), 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            chk("idle_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic pulse_load(input logic [4*N-1:0] v);
        bcd  = v;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_sel"},   32'(digit_sel), 32'h1);
        chk({tag, "_disp"},  32'(display),   32'h3F);
        chk({tag, "_frame"}, 32'(frame),     32'h0);
        chk({tag, "_err"},   32'(err),       32'h0);
    endtask

    initial begin
        frame_t fb;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        load     = 1'b0;
        bcd      = '0;
        blank_en = 1'b0;

        // reset values, during reset and before the first tick
        tick_neg(3);
        chk_reset_vals("rst_hold");
        rst_n = 1'b1;
        tick_neg(1);
        chk_reset_vals("rst_pre_tick");
        tick_neg(1);
        chk("first_tick_sel", 32'(digit_sel), 32'h2);

        // 1234 without blanking, two consecutive frames
        wait_quiet();
        exp_q.push_back(mk(7'h66, 7'h4F, 7'h5B, 7'h06, 1'b0));
        exp_q.push_back(mk(7'h66, 7'h4F, 7'h5B, 7'h06, 1'b0));
        pulse_load(16'h1234);
        wait_idle();

        // 0070 with leading-zero blanking
        wait_quiet();
        blank_en = 1'b1;
        exp_q.push_back(mk(7'h3F, 7'h07, 7'h00, 7'h00, 1'b0));
        pulse_load(16'h0070);
        wait_idle();

        // blanking released in the first cycle of digit 2
        wait_quiet();
        fb = mk(7'h3F, 7'h07, 7'h00, 7'h00, 1'b0);
        fb.seg[5] = 7'h3F;
        fb.seg[6] = 7'h3F;
        fb.seg[7] = 7'h3F;
        exp_q.push_back(fb);
        wait_frame();
        tick_neg(4);
        blank_en = 1'b0;
        wait_idle();

        // invalid nibble raises err and shows a dash, then clears
        wait_quiet();
        exp_q.push_back(mk(7'h6D, 7'h40, 7'h3F, 7'h3F, 1'b1));
        pulse_load(16'h00A5);
        wait_idle();
        wait_quiet();
        exp_q.push_back(mk(7'h67, 7'h3F, 7'h3F, 7'h3F, 1'b0));
        pulse_load(16'h0009);
        wait_idle();

        // two loads in one frame: only the last is shown
        wait_frame();
        tick_neg(1);
        exp_q.push_back(mk(7'h5B, 7'h3F, 7'h3F, 7'h3F, 1'b0));
        pulse_load(16'h0001);
        tick_neg(1);
        pulse_load(16'h0002);
        wait_idle();

        // load on the wrap tick goes straight to the display
        wait_frame();
        tick_neg(7);
        exp_q.push_back(mk(7'h7F, 7'h3F, 7'h3F, 7'h3F, 1'b0));
        pulse_load(16'h0008);
        wait_idle();

        // err set again so the reset check below is meaningful
        wait_quiet();
        exp_q.push_back(mk(7'h4F, 7'h40, 7'h3F, 7'h3F, 1'b1));
        pulse_load(16'h00C3);
        wait_idle();

        // asynchronous reset on digit 2 with a pending load outstanding
        wait_frame();
        tick_neg(1);
        pulse_load(16'h0456);
        tick_neg(2);
        chk("pre_rst_sel", 32'(digit_sel), 32'h4);
        chk("pre_rst_err", 32'(err), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rst_async");
        tick_neg(2);
        chk_reset_vals("rst_mid_hold");
        rst_n = 1'b1;
        exp_q.push_back(mk(7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b0));
        exp_q.push_back(mk(7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b0));
        tick_neg(1);
        chk("post_rst_sel0", 32'(digit_sel), 32'h1);
        tick_neg(1);
        chk("post_rst_sel1", 32'(digit_sel), 32'h2);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d failures", n_checks, n_fail);
        $fatal(1);
    end

endmodule
